rt_access_ctrl: RTL and testbench
=================================

RT_ACCESS_CTRL -- requirements
Module: rt_access_ctrl

Interface
REQ-001 Parameter Nb, default 32: racetrack positions per track and word-line count.
REQ-002 Parameter Np, default 8: access ports per track; P = Nb/Np, a power of two of at least 2.
REQ-003 Parameters Nr, default 4, and NMU, default 8: bits per unit and number of memory units; data width W = Nr*NMU.
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rstn_i  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  request handshake; transfer when both are high at an edge.
REQ-007 req_op_i  in  3  0=RD_DATA, 1=RD_LIM, 2=WR_DATA, 3=WR_MASK, 4=WR_PROG, 5..7 illegal.
REQ-008 req_addr_i / req_wdata_i  in  log2(Nb)/W  target position / write payload.
REQ-009 resp_valid_o / resp_rdata_o / resp_err_o  out  1/W/1  completion pulse, read data, illegal-op flag.
REQ-010 Bz_s_o, Bz_m_o  out  1 each  slave/master clocking-field phases.
REQ-011 current_{s,m}_{lim,data,mask,program}_o  out  1 each  per-track shift currents.
REQ-012 current_read_o, out_select_o  out  1 each  read current; output mux (0 = data, 1 = LIM result).
REQ-013 write_{data,mask,program}_o / write_en_{data,mask,program}_o  out  W / 1 each  write payloads and strobes.
REQ-014 word_lines_o  out  Nb  one-hot word-line select.
REQ-015 r_data_i  in  W  array read output, valid during ACCESS.

Function
REQ-016 FSM states: IDLE, SHIFT_S, SHIFT_M, ACCESS, DONE; req_ready_o SHALL be 1 only in IDLE.
REQ-017 Three offset registers (log2(P) bits each): off_data (shared by the data and LIM tracks), off_mask, off_prog.
REQ-018 Target track per op: RD_DATA/RD_LIM/WR_DATA use off_data; WR_MASK uses off_mask; WR_PROG uses off_prog.
REQ-019 On accept, the block SHALL latch op, addr and wdata, and SHALL compute tgt = addr mod P and steps k = (tgt - off) mod P (unidirectional shift, wrap-around).
REQ-020 From IDLE on accept: k>0 goes to SHIFT_S; k=0 goes to ACCESS; illegal op goes to DONE.
REQ-021 SHIFT_S (1 cycle): Bz_s_o=1 plus current_s_<track>_o; the next state is SHIFT_M.
REQ-022 SHIFT_M (1 cycle): Bz_m_o=1 plus current_m_<track>_o; the offset increments mod P; the next state is SHIFT_S while steps remain, otherwise ACCESS.
REQ-023 RD_LIM SHALL additionally assert current_s_lim_o/current_m_lim_o in the same phases as the data currents.
REQ-024 ACCESS (1 cycle): word_lines_o = one-hot(addr); reads drive current_read_o=1 with out_select_o = (op==RD_LIM), and r_data_i is captured into resp_rdata_o at the end of the cycle.
REQ-025 ACCESS for writes: write_en_<track>_o=1 and write_<track>_o = latched wdata; current_read_o=0.
REQ-026 DONE (1 cycle): resp_valid_o=1; resp_err_o=1 only for an illegal op; the next state is IDLE.
REQ-027 Outside the states listed above, all currents, Bz, strobes, word_lines_o and write payloads SHALL be 0; out_select_o SHALL be 0 outside ACCESS.
REQ-028 Latency from accept edge to resp_valid_o: 2k+2 cycles for legal ops; 1 cycle for an illegal op.
REQ-029 Back-to-back requests: the next accept is possible on the cycle after DONE; throughput is one op per 2k+3 cycles.
REQ-030 resp_rdata_o SHALL hold its value until the next read capture; writes and errors SHALL leave it unchanged.
REQ-031 Illegal ops SHALL perform no shift, no access and no offset change.
REQ-032 No more than one SHIFT or ACCESS drive SHALL be active in any cycle; Bz_s_o and Bz_m_o SHALL never both be high.

Reset
REQ-033 rstn_i low SHALL force: state IDLE, all offsets 0, every output 0 (req_ready_o rises at the first clock edge after release, in IDLE).
REQ-034 Reset mid-shift or mid-access SHALL abort immediately with no response; offsets return to 0, and the array is re-aligned externally before use.

Verification
REQ-035 Reset, then RD_DATA addr=0 -> k=0, ACCESS next cycle with word_lines_o=0x00000001 and current_read_o=1, resp_valid_o 2 cycles after accept with resp_rdata_o=r_data_i.
REQ-036 WR_DATA addr=3 wdata=0xA5A5A5A5 from off_data=0 -> 3 S/M pairs, write_en_data_o=1 with word_lines_o=0x00000008, off_data=3, resp_valid_o at cycle 8.
REQ-037 With off_data=3, RD_LIM addr=9 (tgt=1) -> wrap k=2 with data+lim currents, out_select_o=1 in ACCESS, off_data=1.
REQ-038 WR_MASK addr=2 followed immediately by WR_PROG addr=2 -> off_mask and off_prog each become 2, off_data unchanged, only mask/program currents toggle.
REQ-039 req_op_i=6 -> resp_valid_o and resp_err_o high the next cycle, no currents, no strobes, offsets unchanged.
REQ-040 rstn_i asserted during the second SHIFT_M of a 3-step op -> all outputs 0 asynchronously, no resp_valid_o, next RD_DATA addr=1 shifts k=1.

Source files
------------

// File: rtl/rt_access_ctrl.sv
// Racetrack memory access controller: aligns the addressed track segment under its
// access port with unidirectional S/M clocking-field shifts, then performs one read or write.
`timescale 1ns/1ps
module rt_access_ctrl #(
  parameter int Nb  = 32,
  parameter int Np  = 8,
  parameter int Nr  = 4,
  parameter int NMU = 8,
  localparam int P  = Nb / Np,
  localparam int W  = Nr * NMU,
  localparam int AW = $clog2(Nb),
  localparam int OW = $clog2(P)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    req_op_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [W-1:0]  req_wdata_i,
  output logic          resp_valid_o,
  output logic [W-1:0]  resp_rdata_o,
  output logic          resp_err_o,
  output logic          Bz_s_o,
  output logic          Bz_m_o,
  output logic          current_s_lim_o,
  output logic          current_s_data_o,
  output logic          current_s_mask_o,
  output logic          current_s_program_o,
  output logic          current_m_lim_o,
  output logic          current_m_data_o,
  output logic          current_m_mask_o,
  output logic          current_m_program_o,
  output logic          current_read_o,
  output logic          out_select_o,
  output logic [W-1:0]  write_data_o,
  output logic [W-1:0]  write_mask_o,
  output logic [W-1:0]  write_program_o,
  output logic          write_en_data_o,
  output logic          write_en_mask_o,
  output logic          write_en_program_o,
  output logic [Nb-1:0] word_lines_o,
  input  logic [W-1:0]  r_data_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT_S = 3'd1;
  localparam logic [2:0] S_SHIFT_M = 3'd2;
  localparam logic [2:0] S_ACCESS  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [2:0] OP_RD_DATA = 3'd0;
  localparam logic [2:0] OP_RD_LIM  = 3'd1;
  localparam logic [2:0] OP_WR_DATA = 3'd2;
  localparam logic [2:0] OP_WR_MASK = 3'd3;
  localparam logic [2:0] OP_WR_PROG = 3'd4;

  localparam logic [1:0] TRK_DATA = 2'd0;
  localparam logic [1:0] TRK_MASK = 2'd1;
  localparam logic [1:0] TRK_PROG = 2'd2;

  // Data and LIM tracks move together, so they share one offset register.
  function automatic logic [1:0] track_of(input logic [2:0] op);
    case (op)
      OP_WR_MASK: track_of = TRK_MASK;
      OP_WR_PROG: track_of = TRK_PROG;
      default:    track_of = TRK_DATA;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_WR_PROG;
  endfunction

  function automatic logic op_is_read(input logic [2:0] op);
    return (op == OP_RD_DATA) || (op == OP_RD_LIM);
  endfunction

  logic [2:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [OW-1:0] steps_q, steps_d;
  logic [OW-1:0] off_data_q, off_data_d;
  logic [OW-1:0] off_mask_q, off_mask_d;
  logic [OW-1:0] off_prog_q, off_prog_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          ready_en_q, ready_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  wdata_q, wdata_d;

  logic          accept;
  logic [OW-1:0] req_tgt;
  logic [OW-1:0] req_off;
  logic [OW-1:0] req_k;
  logic [1:0]    trk;
  logic          lim_on;

  assign accept = req_valid_i & req_ready_o;
  assign trk    = track_of(op_q);
  assign lim_on = (op_q == OP_RD_LIM);

  // Shift distance is forward-only: tgt - off wraps naturally in OW bits.
  always_comb begin
    req_tgt = req_addr_i[OW-1:0];
    case (track_of(req_op_i))
      TRK_MASK: req_off = off_mask_q;
      TRK_PROG: req_off = off_prog_q;
      default:  req_off = off_data_q;
    endcase
    req_k = req_tgt - req_off;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    steps_d    = steps_q;
    off_data_d = off_data_q;
    off_mask_d = off_mask_q;
    off_prog_d = off_prog_q;
    rdata_d    = rdata_q;
    ready_en_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = req_op_i;
          if (!op_legal(req_op_i)) begin
            state_d = S_DONE;
          end else if (req_k != '0) begin
            state_d = S_SHIFT_S;
            steps_d = req_k;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_SHIFT_S: state_d = S_SHIFT_M;
      S_SHIFT_M: begin
        case (trk)
          TRK_MASK: off_mask_d = off_mask_q + OW'(1);
          TRK_PROG: off_prog_d = off_prog_q + OW'(1);
          default:  off_data_d = off_data_q + OW'(1);
        endcase
        steps_d = steps_q - OW'(1);
        state_d = (steps_q == OW'(1)) ? S_ACCESS : S_SHIFT_S;
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (op_is_read(op_q)) rdata_d = r_data_i;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = accept ? req_addr_i  : addr_q;
    wdata_d = accept ? req_wdata_i : wdata_q;
  end

  // ready_en_q keeps req_ready_o low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      steps_q    <= '0;
      off_data_q <= '0;
      off_mask_q <= '0;
      off_prog_q <= '0;
      rdata_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      steps_q    <= steps_d;
      off_data_q <= off_data_d;
      off_mask_q <= off_mask_d;
      off_prog_q <= off_prog_d;
      rdata_q    <= rdata_d;
      ready_en_q <= ready_en_d;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign resp_rdata_o = rdata_q;

  // All array drives decode from the registered state, so reset clears them at once.
  always_comb begin
    req_ready_o         = ready_en_q && (state_q == S_IDLE);
    resp_valid_o        = 1'b0;
    resp_err_o          = 1'b0;
    Bz_s_o              = 1'b0;
    Bz_m_o              = 1'b0;
    current_s_lim_o     = 1'b0;
    current_s_data_o    = 1'b0;
    current_s_mask_o    = 1'b0;
    current_s_program_o = 1'b0;
    current_m_lim_o     = 1'b0;
    current_m_data_o    = 1'b0;
    current_m_mask_o    = 1'b0;
    current_m_program_o = 1'b0;
    current_read_o      = 1'b0;
    out_select_o        = 1'b0;
    write_data_o        = '0;
    write_mask_o        = '0;
    write_program_o     = '0;
    write_en_data_o     = 1'b0;
    write_en_mask_o     = 1'b0;
    write_en_program_o  = 1'b0;
    word_lines_o        = '0;
    case (state_q)
      S_SHIFT_S: begin
        Bz_s_o = 1'b1;
        case (trk)
          TRK_MASK: current_s_mask_o = 1'b1;
          TRK_PROG: current_s_program_o = 1'b1;
          default: begin
            current_s_data_o = 1'b1;
            current_s_lim_o  = lim_on;
          end
        endcase
      end
      S_SHIFT_M: begin
        Bz_m_o = 1'b1;
        case (trk)
          TRK_MASK: current_m_mask_o = 1'b1;
          TRK_PROG: current_m_program_o = 1'b1;
          default: begin
            current_m_data_o = 1'b1;
            current_m_lim_o  = lim_on;
          end
        endcase
      end
      S_ACCESS: begin
        word_lines_o = Nb'(1) << addr_q;
        if (op_is_read(op_q)) begin
          current_read_o = 1'b1;
          out_select_o   = lim_on;
        end else begin
          case (trk)
            TRK_MASK: begin
              write_en_mask_o = 1'b1;
              write_mask_o    = wdata_q;
            end
            TRK_PROG: begin
              write_en_program_o = 1'b1;
              write_program_o    = wdata_q;
            end
            default: begin
              write_en_data_o = 1'b1;
              write_data_o    = wdata_q;
            end
          endcase
        end
      end
      S_DONE: begin
        resp_valid_o = 1'b1;
        resp_err_o   = !op_legal(op_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rt_access_ctrl.sv
// Bench for rt_access_ctrl: directed scenarios plus random ops against a
// track-offset model (per-track offsets, modular shift distance, expected drives).
`timescale 1ns/1ps
module tb_rt_access_ctrl;
  localparam int Nb = 32, Np = 8, Nr = 4, NMU = 8;
  localparam int P = Nb / Np, W = Nr * NMU, AW = $clog2(Nb);

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  logic req_valid_i = 1'b0;
  logic [2:0] req_op_i = '0;
  logic [AW-1:0] req_addr_i = '0;
  logic [W-1:0] req_wdata_i = '0;
  logic [W-1:0] r_data_i = '0;
  logic req_ready_o, resp_valid_o, resp_err_o, Bz_s_o, Bz_m_o;
  logic current_s_lim_o, current_s_data_o, current_s_mask_o, current_s_program_o;
  logic current_m_lim_o, current_m_data_o, current_m_mask_o, current_m_program_o;
  logic current_read_o, out_select_o;
  logic write_en_data_o, write_en_mask_o, write_en_program_o;
  logic [W-1:0] resp_rdata_o, write_data_o, write_mask_o, write_program_o;
  logic [Nb-1:0] word_lines_o;

  always #5 clk = ~clk;

  rt_access_ctrl #(.Nb(Nb), .Np(Np), .Nr(Nr), .NMU(NMU)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .Bz_s_o(Bz_s_o), .Bz_m_o(Bz_m_o),
    .current_s_lim_o(current_s_lim_o), .current_s_data_o(current_s_data_o),
    .current_s_mask_o(current_s_mask_o), .current_s_program_o(current_s_program_o),
    .current_m_lim_o(current_m_lim_o), .current_m_data_o(current_m_data_o),
    .current_m_mask_o(current_m_mask_o), .current_m_program_o(current_m_program_o),
    .current_read_o(current_read_o), .out_select_o(out_select_o),
    .write_data_o(write_data_o), .write_mask_o(write_mask_o), .write_program_o(write_program_o),
    .write_en_data_o(write_en_data_o), .write_en_mask_o(write_en_mask_o),
    .write_en_program_o(write_en_program_o),
    .word_lines_o(word_lines_o), .r_data_i(r_data_i)
  );

  wire [3:0] s_cur = {current_s_program_o, current_s_mask_o, current_s_lim_o, current_s_data_o};
  wire [3:0] m_cur = {current_m_program_o, current_m_mask_o, current_m_lim_o, current_m_data_o};
  wire [2:0] wen   = {write_en_program_o, write_en_mask_o, write_en_data_o};
  wire acc_drv   = current_read_o | out_select_o | (|wen) | (|write_data_o) |
                   (|write_mask_o) | (|write_program_o);
  wire any_drive = Bz_s_o | Bz_m_o | (|s_cur) | (|m_cur) | acc_drv | (|word_lines_o);
  wire any_out   = any_drive | req_ready_o | resp_valid_o | resp_err_o | (|resp_rdata_o);

  int tests = 0;
  int fails = 0;

  int m_off[3];
  logic [W-1:0] m_rdata;

  int e_lat, e_k, e_nacc;
  logic [3:0] e_smask;
  logic [Nb-1:0] e_wl;
  logic e_rd, e_sel, e_err;
  logic [2:0] e_wen;
  logic [W-1:0] e_wd, e_wm, e_wp, e_rdata;

  int o_lat, o_ns, o_nm, o_nacc, o_perr;
  logic [3:0] o_smask, o_mmask;
  logic [Nb-1:0] o_wl;
  logic o_rd, o_sel, o_err, o_rdy_busy, o_rdy_after;
  logic [2:0] o_wen;
  logic [W-1:0] o_wd, o_wm, o_wp, o_rdata, acc_r;

  // Reference: each track keeps an offset; k is the forward distance to addr mod P.
  task automatic model_pre(input logic [2:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd);
    int t;
    logic legal;
    legal = (op <= 3'd4);
    t = (op == 3'd3) ? 1 : (op == 3'd4) ? 2 : 0;
    e_k = legal ? ((int'(addr) % P) - m_off[t] + P) % P : 0;
    e_lat = legal ? 2 * e_k + 2 : 1;
    e_smask = '0;
    if (e_k > 0) e_smask = (t == 1) ? 4'b0100 : (t == 2) ? 4'b1000 : (op == 3'd1) ? 4'b0011 : 4'b0001;
    e_nacc = legal ? 1 : 0;
    e_wl = legal ? (Nb'(1) << addr) : '0;
    e_rd = (op <= 3'd1);
    e_sel = (op == 3'd1);
    e_wen = (op == 3'd2) ? 3'b001 : (op == 3'd3) ? 3'b010 : (op == 3'd4) ? 3'b100 : 3'b000;
    e_wd = (op == 3'd2) ? wd : '0;
    e_wm = (op == 3'd3) ? wd : '0;
    e_wp = (op == 3'd4) ? wd : '0;
    e_err = !legal;
    if (legal) m_off[t] = (m_off[t] + e_k) % P;
  endtask

  task automatic model_post();
    e_rdata = e_rd ? acc_r : m_rdata;
    m_rdata = e_rdata;
  endtask

  // Issues one request and records what the DUT drove until the response.
  task automatic run_op(input logic [2:0] op, input logic [AW-1:0] addr, input logic [W-1:0] wd);
    int n;
    logic prev_s;
    o_lat = -1; o_ns = 0; o_nm = 0; o_nacc = 0; o_perr = 0;
    o_smask = '0; o_mmask = '0; o_wl = '0; o_rd = 0; o_sel = 0; o_err = 0;
    o_wen = '0; o_wd = '0; o_wm = '0; o_wp = '0; o_rdata = '0;
    o_rdy_busy = 0; o_rdy_after = 0; acc_r = 'x; prev_s = 0;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      tests++; fails++;
      $display("FAIL ready_wait: req_ready_o got 0 required 1");
    end
    req_op_i = op; req_addr_i = addr; req_wdata_i = wd; req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_op_i = 3'($urandom); req_addr_i = AW'($urandom); req_wdata_i = W'($urandom);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (req_ready_o) o_rdy_busy = 1;
      if (Bz_s_o) o_ns++;
      if (Bz_m_o) o_nm++;
      o_smask |= s_cur;
      o_mmask |= m_cur;
      if (Bz_s_o && Bz_m_o) o_perr++;
      if ((|s_cur) && !Bz_s_o) o_perr++;
      if ((|m_cur) && !Bz_m_o) o_perr++;
      if (Bz_s_o && prev_s) o_perr++;
      if (Bz_m_o && !prev_s) o_perr++;
      if (!$onehot0(word_lines_o)) o_perr++;
      if ((word_lines_o == '0) && acc_drv) o_perr++;
      if ((word_lines_o != '0) && (Bz_s_o || Bz_m_o || resp_valid_o)) o_perr++;
      if (resp_valid_o && (Bz_s_o || Bz_m_o)) o_perr++;
      if (resp_err_o && !resp_valid_o) o_perr++;
      prev_s = Bz_s_o;
      r_data_i = W'($urandom);
      if (word_lines_o != '0) begin
        o_nacc++; o_wl = word_lines_o; o_rd = current_read_o; o_sel = out_select_o;
        o_wen = wen; o_wd = write_data_o; o_wm = write_mask_o; o_wp = write_program_o;
        acc_r = r_data_i;
      end
      if (resp_valid_o) begin
        o_lat = c; o_err = resp_err_o; o_rdata = resp_rdata_o;
        break;
      end
    end
    @(negedge clk);
    o_rdy_after = req_ready_o;
    if (any_drive || resp_valid_o) o_perr++;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (any_out !== 1'b0) begin fails++; $display("FAIL reset_outputs: any output got %b required 0", any_out); end
    rstn_i = 1'b1;
    #1;
    tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready_early: got %b required 0", req_ready_o); end
    @(negedge clk);
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready_rise: got %b required 1", req_ready_o); end
    m_off = '{0, 0, 0};
    m_rdata = '0;
  endtask

  task automatic test_rd_data_k0();
    model_pre(3'd0, 5'd0, 32'h0); run_op(3'd0, 5'd0, 32'h0); model_post();
    tests++; if (o_lat !== 2) begin fails++; $display("FAIL rd0_latency: got %0d required 2", o_lat); end
    tests++; if (o_ns !== 0) begin fails++; $display("FAIL rd0_shifts: got %0d required 0", o_ns); end
    tests++; if (o_wl !== 32'h1) begin fails++; $display("FAIL rd0_wordline: got %h required 00000001", o_wl); end
    tests++; if ({o_rd, o_sel} !== 2'b10) begin fails++; $display("FAIL rd0_read_sel: got %b required 10", {o_rd, o_sel}); end
    tests++; if (o_rdata !== acc_r) begin fails++; $display("FAIL rd0_rdata: got %h required %h", o_rdata, acc_r); end
  endtask

  task automatic test_wr_data();
    model_pre(3'd2, 5'd3, 32'hA5A5A5A5); run_op(3'd2, 5'd3, 32'hA5A5A5A5); model_post();
    tests++; if (o_lat !== 8) begin fails++; $display("FAIL wrd_latency: got %0d required 8", o_lat); end
    tests++; if ({o_ns, o_nm} !== {3, 3}) begin fails++; $display("FAIL wrd_shifts: got %0d/%0d required 3/3", o_ns, o_nm); end
    tests++; if (o_smask !== 4'b0001) begin fails++; $display("FAIL wrd_tracks: got %b required 0001", o_smask); end
    tests++; if (o_wl !== 32'h8) begin fails++; $display("FAIL wrd_wordline: got %h required 00000008", o_wl); end
    tests++; if (o_wen !== 3'b001) begin fails++; $display("FAIL wrd_strobe: got %b required 001", o_wen); end
    tests++; if (o_wd !== 32'hA5A5A5A5) begin fails++; $display("FAIL wrd_payload: got %h required a5a5a5a5", o_wd); end
    tests++; if (o_rdata !== e_rdata) begin fails++; $display("FAIL wrd_rdata_hold: got %h required %h", o_rdata, e_rdata); end
    tests++; if (o_perr !== 0) begin fails++; $display("FAIL wrd_phase_rules: got %0d violations required 0", o_perr); end
  endtask

  task automatic test_rd_lim_wrap();
    model_pre(3'd1, 5'd9, 32'h0); run_op(3'd1, 5'd9, 32'h0); model_post();
    tests++; if (o_lat !== 6) begin fails++; $display("FAIL lim_latency: got %0d required 6", o_lat); end
    tests++; if ({o_smask, o_mmask} !== 8'b0011_0011) begin fails++; $display("FAIL lim_currents: got %b/%b required 0011/0011", o_smask, o_mmask); end
    tests++; if ({o_rd, o_sel} !== 2'b11) begin fails++; $display("FAIL lim_read_sel: got %b required 11", {o_rd, o_sel}); end
    tests++; if (o_rdata !== acc_r) begin fails++; $display("FAIL lim_rdata: got %h required %h", o_rdata, acc_r); end
    model_pre(3'd0, 5'd1, 32'h0); run_op(3'd0, 5'd1, 32'h0); model_post();
    tests++; if (o_lat !== 2) begin fails++; $display("FAIL lim_offset_after: latency got %0d required 2", o_lat); end
  endtask

  task automatic test_back_to_back_mask_prog();
    logic [W-1:0] wd;
    wd = W'($urandom);
    model_pre(3'd3, 5'd2, wd); run_op(3'd3, 5'd2, wd); model_post();
    tests++; if ({o_ns, o_smask, o_mmask} !== {2, 8'b0100_0100}) begin fails++; $display("FAIL mask_shift: got %0d %b/%b required 2 0100/0100", o_ns, o_smask, o_mmask); end
    tests++; if ({o_wen, o_wm} !== {3'b010, wd}) begin fails++; $display("FAIL mask_write: got %b %h required 010 %h", o_wen, o_wm, wd); end
    tests++; if (o_rdata !== e_rdata) begin fails++; $display("FAIL mask_rdata_hold: got %h required %h", o_rdata, e_rdata); end
    tests++; if ({o_rdy_busy, o_rdy_after} !== 2'b01) begin fails++; $display("FAIL b2b_ready: busy/after got %b required 01", {o_rdy_busy, o_rdy_after}); end
    wd = W'($urandom);
    model_pre(3'd4, 5'd2, wd); run_op(3'd4, 5'd2, wd); model_post();
    tests++; if (o_lat !== 6) begin fails++; $display("FAIL prog_latency: got %0d required 6", o_lat); end
    tests++; if ({o_ns, o_smask, o_mmask} !== {2, 8'b1000_1000}) begin fails++; $display("FAIL prog_shift: got %0d %b/%b required 2 1000/1000", o_ns, o_smask, o_mmask); end
    tests++; if ({o_wen, o_wp} !== {3'b100, wd}) begin fails++; $display("FAIL prog_write: got %b %h required 100 %h", o_wen, o_wp, wd); end
    model_pre(3'd0, 5'd1, 32'h0); run_op(3'd0, 5'd1, 32'h0); model_post();
    tests++; if (o_lat !== 2) begin fails++; $display("FAIL data_offset_kept: latency got %0d required 2", o_lat); end
  endtask

  task automatic test_illegal();
    model_pre(3'd6, 5'd7, 32'h0); run_op(3'd6, 5'd7, 32'h0); model_post();
    tests++; if ({o_lat, o_err} !== {1, 1'b1}) begin fails++; $display("FAIL illegal_resp: latency/err got %0d/%b required 1/1", o_lat, o_err); end
    tests++; if ({o_ns, o_nm, o_nacc} !== {0, 0, 0}) begin fails++; $display("FAIL illegal_activity: shifts/access got %0d/%0d/%0d required 0/0/0", o_ns, o_nm, o_nacc); end
    tests++; if ({o_smask, o_mmask, o_wen} !== '0) begin fails++; $display("FAIL illegal_drives: got %b %b %b required zeros", o_smask, o_mmask, o_wen); end
    tests++; if (o_rdata !== e_rdata) begin fails++; $display("FAIL illegal_rdata_hold: got %h required %h", o_rdata, e_rdata); end
  endtask

  task automatic test_reset_midshift();
    logic [AW-1:0] a;
    logic saw_resp;
    int n;
    a = AW'(((m_off[1] + 3) % P) + P * $urandom_range(0, Nb / P - 1));
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_op_i = 3'd3; req_addr_i = a; req_wdata_i = W'($urandom); req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (Bz_m_o !== 1'b1) begin fails++; $display("FAIL midshift_phase: Bz_m_o got %b required 1", Bz_m_o); end
    rstn_i = 1'b0;
    #1;
    tests++; if (any_out !== 1'b0) begin fails++; $display("FAIL midshift_async_clear: got %b required 0", any_out); end
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    saw_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_resp |= resp_valid_o;
    end
    tests++; if (saw_resp !== 1'b0) begin fails++; $display("FAIL midshift_no_resp: got %b required 0", saw_resp); end
    m_off = '{0, 0, 0};
    m_rdata = '0;
    model_pre(3'd0, 5'd1, 32'h0); run_op(3'd0, 5'd1, 32'h0); model_post();
    tests++; if ({o_lat, o_ns} !== {4, 1}) begin fails++; $display("FAIL midshift_realign: latency/shifts got %0d/%0d required 4/1", o_lat, o_ns); end
    tests++; if (o_rdata !== acc_r) begin fails++; $display("FAIL midshift_rdata: got %h required %h", o_rdata, acc_r); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [AW-1:0] a;
    logic [W-1:0] wd;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      a = AW'($urandom);
      wd = W'($urandom);
      model_pre(op, a, wd); run_op(op, a, wd); model_post();
      tests++; if (o_lat !== e_lat) begin fails++; $display("FAIL rnd%0d_latency op%0d: got %0d required %0d", i, op, o_lat, e_lat); end
      tests++; if ({o_ns, o_nm} !== {e_k, e_k}) begin fails++; $display("FAIL rnd%0d_shifts: got %0d/%0d required %0d", i, o_ns, o_nm, e_k); end
      tests++; if ({o_smask, o_mmask} !== {e_smask, e_smask}) begin fails++; $display("FAIL rnd%0d_currents: got %b/%b required %b", i, o_smask, o_mmask, e_smask); end
      tests++; if ({o_nacc, o_wl} !== {e_nacc, e_wl}) begin fails++; $display("FAIL rnd%0d_access: got %0d %h required %0d %h", i, o_nacc, o_wl, e_nacc, e_wl); end
      tests++; if ({o_rd, o_sel, o_wen} !== {e_rd, e_sel, e_wen}) begin fails++; $display("FAIL rnd%0d_mode: got %b required %b", i, {o_rd, o_sel, o_wen}, {e_rd, e_sel, e_wen}); end
      tests++; if ({o_wd, o_wm, o_wp} !== {e_wd, e_wm, e_wp}) begin fails++; $display("FAIL rnd%0d_payload: got %h %h %h required %h %h %h", i, o_wd, o_wm, o_wp, e_wd, e_wm, e_wp); end
      tests++; if (o_err !== e_err) begin fails++; $display("FAIL rnd%0d_err: got %b required %b", i, o_err, e_err); end
      tests++; if (o_rdata !== e_rdata) begin fails++; $display("FAIL rnd%0d_rdata: got %h required %h", i, o_rdata, e_rdata); end
      tests++; if ({o_rdy_busy, o_rdy_after} !== 2'b01) begin fails++; $display("FAIL rnd%0d_ready: busy/after got %b required 01", i, {o_rdy_busy, o_rdy_after}); end
      tests++; if (o_perr !== 0) begin fails++; $display("FAIL rnd%0d_phase_rules: got %0d violations required 0", i, o_perr); end
    end
  endtask

  initial begin
    test_reset();
    test_rd_data_k0();
    test_wr_data();
    test_rd_lim_wrap();
    test_back_to_back_mask_prog();
    test_illegal();
    test_reset_midshift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
